// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register address
// width, forwarding select codes and the shadow pipeline stage record.
package mips_pkg;

  localparam int RADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memread;
    logic [RADDR_W-1:0] wa;
  } stage_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer
// (MEM before WB) of the EX-stage source register, else the register file.
module fwd_sel
  import mips_pkg::*;
#(
  parameter logic [RADDR_W-1:0] ZERO_REG = '0
) (
  input  logic               use_src,
  input  logic [RADDR_W-1:0] src,
  input  logic               mem_valid,
  input  logic               mem_regwrite,
  input  logic [RADDR_W-1:0] mem_wa,
  input  logic               wb_valid,
  input  logic               wb_regwrite,
  input  logic [RADDR_W-1:0] wb_wa,
  output logic [1:0]         sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_valid && mem_regwrite && (mem_wa != ZERO_REG) && use_src && (mem_wa == src);
  assign wb_hit  = wb_valid  && wb_regwrite  && (wb_wa  != ZERO_REG) && use_src && (wb_wa  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller for the 5-stage MIPS core.
// Optional HAZARD_PERF_EN adds stall/flush/freeze event counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter logic [RADDR_W-1:0] ZERO_REG = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [RADDR_W-1:0] id_wa,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_jump,
  input  logic               id_jumpr,
  input  logic               ex_redirect,
  input  logic               ext_stall,
  output logic               pc_stall,
  output logic               ifid_stall,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        freeze_cnt
`endif
);

  stage_t             ex_q;
  stage_t             mem_q;
  stage_t             wb_q;
  logic [RADDR_W-1:0] ex_rs;
  logic [RADDR_W-1:0] ex_rt;
  logic               ex_use_rs;
  logic               ex_use_rt;

  logic               load_use;
  logic               jump_take;
  logic [1:0]         sel_a;
  logic [1:0]         sel_b;

  // jr is resolved in EX and reaches this block only through ex_redirect
  logic               unused_jumpr;
  assign unused_jumpr = id_jumpr;

  assign load_use = ex_q.valid && ex_q.memread && (ex_q.wa != ZERO_REG) && id_valid &&
                    ((id_use_rs && (id_rs == ex_q.wa)) || (id_use_rt && (id_rt == ex_q.wa)));

  assign jump_take = id_valid && id_jump && !load_use && !ex_redirect;

  // A redirect squashes the ID instruction, so it wins over a pending load-use stall
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (ext_stall) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else begin
      pc_stall   = load_use && !ex_redirect;
      ifid_stall = load_use && !ex_redirect;
      ifid_flush = ex_redirect || jump_take;
      idex_flush = ex_redirect || load_use;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
    end else if (!ext_stall) begin
      if (idex_flush || !id_valid) begin
        ex_q      <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_use_rs <= 1'b0;
        ex_use_rt <= 1'b0;
      end else begin
        ex_q.valid    <= 1'b1;
        ex_q.regwrite <= id_regwrite;
        ex_q.memread  <= id_memread;
        ex_q.wa       <= id_wa;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_use_rs     <= id_use_rs;
        ex_use_rt     <= id_use_rt;
      end
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  fwd_sel #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .use_src      (ex_use_rs),
    .src          (ex_rs),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_wa       (mem_q.wa),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_wa        (wb_q.wa),
    .sel          (sel_a)
  );

  fwd_sel #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .use_src      (ex_use_rt),
    .src          (ex_rt),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_wa       (mem_q.wa),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_wa        (wb_q.wa),
    .sel          (sel_b)
  );

  assign fwd_a = rst ? FWD_RF : sel_a;
  assign fwd_b = rst ? FWD_RF : sel_b;

`ifdef HAZARD_PERF_EN
  // Event counters wrap naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (ext_stall) begin
      freeze_cnt <= freeze_cnt + 32'd1;
    end else begin
      if (load_use && !ex_redirect) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ifid_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, compared against an instruction-level pipeline model.
module tb_hazard_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_wa;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_jump;
  logic       id_jumpr;
  logic       ex_redirect;
  logic       ext_stall;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wa       (id_wa),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_jump     (id_jump),
    .id_jumpr    (id_jumpr),
    .ex_redirect (ex_redirect),
    .ext_stall   (ext_stall),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt)
`endif
  );

  // Model: the in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    bit valid;
    bit regwrite;
    bit memread;
    bit use_rs;
    bit use_rt;
    int wa;
    int rs;
    int rt;
  } instr_t;

  instr_t      pipe[3];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned m_stall    = 0;
  int unsigned m_flush    = 0;
  int unsigned m_freeze   = 0;

  function automatic instr_t emptySlot();
    instr_t e;
    e = '{default: 0};
    return e;
  endfunction

  // Youngest older producer of the register wins; its pipeline distance is the select code
  function automatic int producerFor(bit uses, int src);
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].valid && pipe[k].regwrite && pipe[k].wa != 0 && uses && pipe[k].wa == src)
        return k;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic setId(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int wa, input bit rw, input bit mr, input bit j);
    id_valid    = v;
    id_rs       = rs[4:0];
    id_use_rs   = urs;
    id_rt       = rt[4:0];
    id_use_rt   = urt;
    id_wa       = wa[4:0];
    id_regwrite = rw;
    id_memread  = mr;
    id_jump     = j;
    id_jumpr    = 1'b0;
  endtask

  // One cycle: inputs already driven just after a rising edge; check mid-cycle, then advance
  task automatic applyStimulus();
    bit     lu;
    bit     e_pc, e_ifs, e_iff, e_idf;
    int     e_fa, e_fb;
    instr_t incoming;
    #4;
    lu = pipe[0].valid && pipe[0].memread && pipe[0].wa != 0 && id_valid &&
         ((id_use_rs && int'(id_rs) == pipe[0].wa) || (id_use_rt && int'(id_rt) == pipe[0].wa));
    {e_pc, e_ifs, e_iff, e_idf} = 4'b0000;
    if (rst)                      {e_pc, e_ifs, e_iff, e_idf} = 4'b0000;
    else if (ext_stall)           {e_pc, e_ifs, e_iff, e_idf} = 4'b1100;
    else if (ex_redirect)         {e_pc, e_ifs, e_iff, e_idf} = 4'b0011;
    else if (lu)                  {e_pc, e_ifs, e_iff, e_idf} = 4'b1101;
    else if (id_valid && id_jump) {e_pc, e_ifs, e_iff, e_idf} = 4'b0010;
    e_fa = rst ? 0 : producerFor(pipe[0].use_rs, pipe[0].rs);
    e_fb = rst ? 0 : producerFor(pipe[0].use_rt, pipe[0].rt);
    checkOutput("pc_stall",   32'(pc_stall),   32'(e_pc));
    checkOutput("ifid_stall", 32'(ifid_stall), 32'(e_ifs));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    checkOutput("idex_flush", 32'(idex_flush), 32'(e_idf));
    checkOutput("fwd_a",      32'(fwd_a),      32'(e_fa));
    checkOutput("fwd_b",      32'(fwd_b),      32'(e_fb));
`ifdef HAZARD_PERF_EN
    checkOutput("stall_cnt",  stall_cnt,  m_stall);
    checkOutput("flush_cnt",  flush_cnt,  m_flush);
    checkOutput("freeze_cnt", freeze_cnt, m_freeze);
`endif
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = emptySlot();
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else if (ext_stall) begin
      m_freeze++;
    end else begin
      if (lu && !ex_redirect) m_stall++;
      if (e_iff) m_flush++;
      incoming = emptySlot();
      if (id_valid && !e_idf) begin
        incoming.valid    = 1;
        incoming.regwrite = id_regwrite;
        incoming.memread  = id_memread;
        incoming.use_rs   = id_use_rs;
        incoming.use_rt   = id_use_rt;
        incoming.wa       = int'(id_wa);
        incoming.rs       = int'(id_rs);
        incoming.rt       = int'(id_rt);
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = incoming;
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = emptySlot();
    rst = 1'b1; ex_redirect = 1'b0; ext_stall = 1'b0;
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus();
    rst = 1'b0;

    $display("[TB] load-use: lw $2 then add $3,$2,$4");
    setId(1, 0, 0, 0, 0, 2, 1, 1, 0); applyStimulus();
    setId(1, 2, 1, 4, 1, 3, 1, 0, 0); applyStimulus();
    applyStimulus();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();
    applyStimulus();

    $display("[TB] MEM beats WB for $5");
    setId(1, 1, 1, 1, 1, 5, 1, 0, 0); applyStimulus();
    setId(1, 2, 1, 2, 1, 5, 1, 0, 0); applyStimulus();
    setId(1, 5, 1, 6, 1, 7, 1, 0, 0); applyStimulus();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();

    $display("[TB] zero register never stalls or forwards");
    setId(1, 0, 0, 0, 0, 0, 1, 1, 0); applyStimulus();
    setId(1, 0, 1, 0, 1, 0, 1, 0, 0); applyStimulus();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();

    $display("[TB] redirect overrides load-use");
    setId(1, 0, 0, 0, 0, 2, 1, 1, 0); applyStimulus();
    setId(1, 2, 1, 0, 0, 3, 1, 0, 0); ex_redirect = 1'b1; applyStimulus();
    ex_redirect = 1'b0;
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();

    $display("[TB] jal then consumer of $31");
    setId(1, 0, 0, 0, 0, 31, 1, 0, 1); applyStimulus();
    setId(1, 31, 1, 0, 0, 8, 1, 0, 0); applyStimulus();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0); applyStimulus();

    $display("[TB] freeze for 3 cycles then reset");
    setId(1, 0, 0, 0, 0, 4, 1, 1, 0); applyStimulus();
    setId(1, 4, 1, 4, 1, 9, 1, 0, 0); ext_stall = 1'b1;
    applyStimulus(); applyStimulus(); applyStimulus();
    rst = 1'b1; applyStimulus();
    ext_stall = 1'b0; rst = 1'b0; applyStimulus();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      ext_stall   = ($urandom_range(0, 5) == 0);
      ex_redirect = ($urandom_range(0, 5) == 0);
      setId($urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
      id_jumpr = $urandom_range(0, 1);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
